// File: rtl/board_generator_if.sv
// Request/board bus between the menu FSM (master) and board_generator (slave).
// INITIAL_BOARD is indexed [row][col], with a 3-bit colour in each cell.
interface board_generator_if #(
  parameter int MAX_SIZE = 26
);
  logic [4:0]                             SIZE;
  logic [3:0]                             COLOR_NUM;
  logic                                   GEN_REQ;
  logic                                   GEN_BUSY;
  logic                                   GEN_DONE;
  logic [MAX_SIZE-1:0][MAX_SIZE-1:0][2:0] INITIAL_BOARD;

  modport master (
    output SIZE, COLOR_NUM, GEN_REQ,
    input  GEN_BUSY, GEN_DONE, INITIAL_BOARD
  );

  modport slave (
    input  SIZE, COLOR_NUM, GEN_REQ,
    output GEN_BUSY, GEN_DONE, INITIAL_BOARD
  );
endinterface

// File: rtl/board_generator.sv
// Fills INITIAL_BOARD with LFSR-driven colours using rejection sampling.
// Optional BOARD_GEN_FREE_SEED_EN mixes a free-running counter into the LFSR on each request.
module board_generator #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          MAX_SIZE     = 26,
  parameter int          REJECT_LIMIT = 7
) (
  input  logic             CLOCK,
  input  logic             RESET,
  board_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [4:0]  SZ_MAX    = 5'(MAX_SIZE);
  localparam logic [2:0]  REJ_MAX   = 3'(REJECT_LIMIT);

  state_t      state;
  state_t      state_next;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [15:0] lfsr_load;
  logic [4:0]  sz;
  logic [3:0]  nc;
  logic [4:0]  row;
  logic [4:0]  col;
  logic [2:0]  rej;
  logic [2:0]  cand;
  logic        cand_ok;
  logic        cell_write;
  logic [2:0]  cell_val;
  logic        last_col;
  logic        last_cell;
  logic        accept;
  logic        busy;
  logic        done;
  logic [MAX_SIZE-1:0][MAX_SIZE-1:0][2:0] board;

  function automatic logic [4:0] clamp_size(input logic [4:0] s);
    if (s < 5'd2)   return 5'd2;
    if (s > SZ_MAX) return SZ_MAX;
    return s;
  endfunction

  function automatic logic [3:0] clamp_colors(input logic [3:0] n);
    if (n < 4'd2) return 4'd2;
    if (n > 4'd8) return 4'd8;
    return n;
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

`ifdef BOARD_GEN_FREE_SEED_EN
  logic [15:0] free_cnt;
  logic [15:0] mixed;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) free_cnt <= 16'h0000;
    else       free_cnt <= free_cnt + 16'h0001;
  end

  assign mixed     = lfsr ^ free_cnt;
  assign lfsr_load = (mixed == 16'h0000) ? 16'h0001 : mixed;
`else
  assign lfsr_load = lfsr;
`endif

  // A rejected candidate costs a cycle; after REJECT_LIMIT misses the low bit is forced in,
  // which is always a legal colour because nc is at least 2.
  assign cand       = lfsr[2:0];
  assign cand_ok    = {1'b0, cand} < nc;
  assign cell_write = (state == FILL) && (cand_ok || (rej == REJ_MAX));
  assign cell_val   = cand_ok ? cand : (cand & 3'b001);
  assign last_col   = (col == sz - 5'd1);
  assign last_cell  = last_col && (row == sz - 5'd1);
  assign accept     = (state == IDLE) && bus.GEN_REQ;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.GEN_REQ) state_next = CLEAR;
      end
      CLEAR: begin
        busy       = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (cell_write && last_cell) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      lfsr <= SEED_SAFE;
      sz   <= 5'd0;
      nc   <= 4'd0;
      row  <= 5'd0;
      col  <= 5'd0;
      rej  <= 3'd0;
    end else begin
      if (accept) begin
        lfsr <= lfsr_load;
        sz   <= clamp_size(bus.SIZE);
        nc   <= clamp_colors(bus.COLOR_NUM);
        row  <= 5'd0;
        col  <= 5'd0;
        rej  <= 3'd0;
      end
      if (state == FILL) begin
        lfsr <= lfsr_next;
        if (cell_write) begin
          rej <= 3'd0;
          if (last_col) begin
            col <= 5'd0;
            row <= row + 5'd1;
          end else begin
            col <= col + 5'd1;
          end
        end else begin
          rej <= rej + 3'd1;
        end
      end
    end
  end

  // Inside the active area old colours survive until overwritten; only the margin is cleared.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      board <= '0;
    end else if (state == CLEAR) begin
      for (int r = 0; r < MAX_SIZE; r++) begin
        for (int c = 0; c < MAX_SIZE; c++) begin
          if ((r >= int'(sz)) || (c >= int'(sz))) board[r][c] <= 3'd0;
        end
      end
    end else if (cell_write) begin
      board[row][col] <= cell_val;
    end
  end

  assign bus.GEN_BUSY      = busy;
  assign bus.GEN_DONE      = done;
  assign bus.INITIAL_BOARD = board;

endmodule

// File: tb/tb_board_generator.sv
// Scoreboard bench for board_generator: a cell-by-cell reference model predicts each board
// and its latency; a negedge monitor compares them whenever GEN_DONE pulses.
module tb_board_generator;

  localparam int          MAX_SIZE     = 26;
  localparam int          REJECT_LIMIT = 7;
  localparam logic [15:0] SEED         = 16'hACE1;

  typedef logic [MAX_SIZE-1:0][MAX_SIZE-1:0][2:0] board_t;
  typedef struct {
    board_t board;
    int     latency;
    int     sz;
    int     nc;
  } exp_t;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  board_generator_if #(.MAX_SIZE(MAX_SIZE)) bus ();

  board_generator #(
    .SEED(SEED),
    .MAX_SIZE(MAX_SIZE),
    .REJECT_LIMIT(REJECT_LIMIT)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  int          done_cyc[$];
  board_t      done_boards[$];
  logic [15:0] model_lfsr;
  board_t      model_board;
  int          accept_cyc = 0;
  bit          accept_pending = 0;
  exp_t        mon_e;
  board_t      zero_board = '0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_board(input string name, input board_t expected);
    int diffs = 0;
    int fr = -1;
    int fc = -1;
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++)
        if (bus.INITIAL_BOARD[r][c] !== expected[r][c]) begin
          diffs++;
          if (fr < 0) begin fr = r; fc = c; end
        end
    vec_cnt++;
    if (diffs != 0) begin
      miss_cnt++;
      $display("[TB] FAIL %s: %0d cells differ, first [%0d][%0d] got %0d expected %0d",
               name, diffs, fr, fc, bus.INITIAL_BOARD[fr][fc], expected[fr][fc]);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Draw candidates until a cell is placed; each draw is one fill cycle.
  task automatic model_gen(input logic [4:0] size_req, input logic [3:0] color_req, output exp_t e);
    int sz = (size_req < 2) ? 2 : ((size_req > MAX_SIZE) ? MAX_SIZE : int'(size_req));
    int nc = (color_req < 2) ? 2 : ((color_req > 8) ? 8 : int'(color_req));
    int cycles = 2;
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++)
        if (r >= sz || c >= sz) model_board[r][c] = 3'd0;
    for (int r = 0; r < sz; r++)
      for (int c = 0; c < sz; c++) begin
        int rej = 0;
        bit placed = 0;
        logic [2:0] cand;
        logic [2:0] val = 3'd0;
        while (!placed) begin
          cand = model_lfsr[2:0];
          model_lfsr = lfsr_step(model_lfsr);
          cycles++;
          if (int'(cand) < nc) begin
            val = cand; placed = 1;
          end else if (rej == REJECT_LIMIT) begin
            val = cand & 3'b001; placed = 1;
          end else begin
            rej++;
          end
        end
        model_board[r][c] = val;
      end
    e.board = model_board;
    e.latency = cycles;
    e.sz = sz;
    e.nc = nc;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.GEN_REQ = 1'b0;
    exp_q.delete();
    model_lfsr = SEED;
    model_board = '0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(posedge CLOCK); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.GEN_BUSY !== 1'b0) && n < 8000) begin
      @(posedge CLOCK); #1;
      n++;
    end
    if (n >= 8000) begin
      vec_cnt++;
      miss_cnt++;
      $display("[TB] FAIL %s_timeout: got %0d pending boards, expected 0", name, exp_q.size());
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] size_req, input logic [3:0] color_req, output exp_t e);
    wait_idle("idle");
    bus.SIZE = size_req;
    bus.COLOR_NUM = color_req;
    bus.GEN_REQ = 1'b1;
    model_gen(size_req, color_req, e);
    exp_q.push_back(e);
    @(posedge CLOCK); #1;
    bus.GEN_REQ = 1'b0;
    bus.SIZE = 5'($urandom);
    bus.COLOR_NUM = 4'($urandom);
  endtask

  // Monitor: notes acceptances, then scores every GEN_DONE against the oldest expectation.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        accept_pending = 0;
        continue;
      end
      if (accept_pending) begin
        check_output("busy_rise", bus.GEN_BUSY, 1);
        accept_pending = 0;
      end
      if (bus.GEN_BUSY === 1'b0 && bus.GEN_REQ === 1'b1) begin
        accept_cyc = cyc;
        accept_pending = 1;
      end
      if (bus.GEN_DONE === 1'b1) begin
        done_cyc.push_back(cyc);
        done_boards.push_back(bus.INITIAL_BOARD);
        if (exp_q.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("[TB] FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          int bad = 0;
          mon_e = exp_q.pop_front();
          check_output("latency", cyc - accept_cyc, mon_e.latency);
          check_output("lat_bounds",
                       (mon_e.latency >= mon_e.sz * mon_e.sz + 2) &&
                       (cyc - accept_cyc <= mon_e.sz * mon_e.sz * (REJECT_LIMIT + 1) + 2), 1);
          check_board("board", mon_e.board);
          for (int r = 0; r < MAX_SIZE; r++)
            for (int c = 0; c < MAX_SIZE; c++)
              if ((r < mon_e.sz && c < mon_e.sz) ? (int'(bus.INITIAL_BOARD[r][c]) >= mon_e.nc)
                                                 : (bus.INITIAL_BOARD[r][c] != 3'd0))
                bad++;
          check_output("range", bad, 0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    exp_t e2;
    board_t first_board;
    int base;
    int n;

    bus.SIZE = 5'd0;
    bus.COLOR_NUM = 4'd0;
    bus.GEN_REQ = 1'b0;
    do_reset();
    check_output("rst_busy", bus.GEN_BUSY, 0);
    check_output("rst_done", bus.GEN_DONE, 0);
    check_board("rst_board", zero_board);

    $display("[TB] smallest board, 2x2 with 8 colours");
    apply_stimulus(5'd2, 4'd8, e);
    first_board = e.board;
    wait_idle("small");

    $display("[TB] 26x26 with 3 colours, GEN_REQ toggling during fill");
    apply_stimulus(5'd26, 4'd3, e);
    for (int i = 0; i < 200; i++) begin
      bus.GEN_REQ = 1'($urandom_range(0, 1));
      @(posedge CLOCK); #1;
    end
    bus.GEN_REQ = 1'b0;
    wait_idle("full");

    $display("[TB] clamped request then smaller board");
    apply_stimulus(5'd31, 4'd1, e);
    apply_stimulus(5'd6, 4'd5, e);
    wait_idle("clamp");

    $display("[TB] randomised requests");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), e);
    end
    wait_idle("random");

    $display("[TB] GEN_REQ held across two boards");
    base = done_cyc.size();
    wait_idle("held_pre");
    bus.SIZE = 5'd4;
    bus.COLOR_NUM = 4'd4;
    bus.GEN_REQ = 1'b1;
    model_gen(5'd4, 4'd4, e);
    exp_q.push_back(e);
    model_gen(5'd4, 4'd4, e2);
    exp_q.push_back(e2);
    n = 0;
    while (!(done_cyc.size() > base && bus.GEN_BUSY === 1'b1) && n < 2000) begin
      @(posedge CLOCK); #1;
      n++;
    end
    bus.GEN_REQ = 1'b0;
    wait_idle("held");
    check_output("held_two_done", done_cyc.size() - base, 2);
    if (done_cyc.size() - base == 2) begin
      check_output("held_gap", done_cyc[base + 1] - done_cyc[base], e2.latency + 1);
      check_output("held_differ", done_boards[base] != done_boards[base + 1], 1);
    end

    $display("[TB] reset in the middle of a 14x14 fill");
    do_reset();
    base = done_cyc.size();
    apply_stimulus(5'd14, 4'd8, e);
    repeat (51) @(posedge CLOCK);
    #2;
    RESET = 1'b1;
    #1;
    check_output("abort_busy", bus.GEN_BUSY, 0);
    check_output("abort_done", bus.GEN_DONE, 0);
    check_board("abort_board", zero_board);
    exp_q.delete();
    model_lfsr = SEED;
    model_board = '0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    check_output("abort_no_done", done_cyc.size(), base);
    apply_stimulus(5'd2, 4'd8, e);
    wait_idle("repro");
    check_board("repro_board", first_board);

    $display("[TB] request timing does not change the board");
    do_reset();
    repeat (100) @(posedge CLOCK);
    #1;
    apply_stimulus(5'd5, 4'd6, e);
    wait_idle("t100");
    first_board = e.board;
    do_reset();
    repeat (101) @(posedge CLOCK);
    #1;
    apply_stimulus(5'd5, 4'd6, e);
    wait_idle("t101");
    check_board("timing_board", first_board);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
